// File: rtl/crossbar_config_pkg.sv
// crossbar_config_pkg: shared FSM encoding, route sentinel and FIFO entry layout
// Entry layout (MSB..LSB): {clear, from[W-1:0], to[W-1:0]}
package crossbar_config_pkg;
  localparam int ROUTE_NONE = -1;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  function automatic int entry_width(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/crossbar_config_if.sv
// crossbar_config_if: route-request valid/ready channel
// valid/ready: handshake; clear: clear-all request; from/to: signed W-bit route indices
interface crossbar_config_if #(parameter int W = 3);
  logic valid, ready, clear;
  logic [W-1:0] from, to;
  modport master(output valid, clear, from, to, input ready);
  modport slave(input valid, clear, from, to, output ready);
endinterface

// File: rtl/crossbar_cmd_fifo.sv
// crossbar_cmd_fifo: synchronous command FIFO with async active-high reset
// push/din: write; pop: advance head; full/empty: occupancy flags; head: oldest entry
module crossbar_cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  always_ff @(posedge clock)
    if (push && !full) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/crossbar_config.sv
// crossbar_config: route-command sequencer driving the crossbar from/to/put port
// clock/reset: rising-edge clock, async active-high reset
// req: request channel (slave); from/to/put: crossbar command, put is a one-cycle strobe
// drop: out-of-range destination discarded; busy: queue non-empty or clear walk running
// rd_to/rd_from: registered shadow-table readback
// CROSSBAR_CONFIG_READBACK_EN: enables shadow table; otherwise rd_from is constant -1
module crossbar_config import crossbar_config_pkg::*; #(
  parameter int W = 3,
  parameter int M = 4,
  parameter int N = 4,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  crossbar_config_if.slave req,
  output logic [W-1:0] from,
  output logic [W-1:0] to,
  output logic         put,
  output logic         drop,
  output logic         busy,
  input  logic [W-1:0] rd_to,
  output logic [W-1:0] rd_from
);
  localparam int EW = entry_width(W);
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [W-1:0] NONE = W'(ROUTE_NONE);
  logic [EW-1:0] head;
  logic full, empty, pop, h_clear, to_ok, from_ok;
  logic [W-1:0] h_from, h_to, cmd_from, cmd_to, from_q, to_q;
  logic [KW-1:0] k, k_n;
  state_t state, state_n;
  assign {h_clear, h_from, h_to} = head;
  assign req.ready = ~full;
  crossbar_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clock,
    .reset,
    .push(req.valid & ~full),
    .pop,
    .din({req.clear, req.from, req.to}),
    .full,
    .empty,
    .head
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      k <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
    end
  always_comb begin
    state_n = state == IDLE ? (!empty && h_clear ? CLEAR : IDLE) : (k == KW'(N - 1) ? IDLE : CLEAR);
    k_n = state == CLEAR ? k + KW'(1) : '0;
  end
  // Strobes decode straight from registered state and FIFO head, so a request
  // accepted at one edge is issued in the very next cycle.
  always_comb begin
    to_ok = !h_to[W-1] && int'(h_to) < N;
    from_ok = !h_from[W-1] && int'(h_from) < M;
    pop = state == IDLE && !empty;
    put = state == CLEAR || (pop && !h_clear && to_ok);
    drop = pop && !h_clear && !to_ok;
    cmd_from = state == CLEAR || !from_ok ? NONE : h_from;
    cmd_to = state == CLEAR ? W'(k) : h_to;
    from = put ? cmd_from : from_q;
    to = put ? cmd_to : to_q;
    busy = !empty || state == CLEAR;
  end
  // from/to keep the last issued command while put is low
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      from_q <= NONE;
      to_q <= '0;
    end else if (put) begin
      from_q <= cmd_from;
      to_q <= cmd_to;
    end
`ifdef CROSSBAR_CONFIG_READBACK_EN
  logic [W-1:0] shadow [N];
  logic rd_ok;
  assign rd_ok = !rd_to[W-1] && int'(rd_to) < N;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < N; i++) shadow[i] <= NONE;
      rd_from <= NONE;
    end else begin
      if (put) shadow[to[KW-1:0]] <= from;
      rd_from <= rd_ok ? shadow[rd_to[KW-1:0]] : NONE;
    end
`else
  logic unused_rd;
  assign unused_rd = ^rd_to;
  assign rd_from = NONE;
`endif
endmodule
